// File: rtl/cf_fft_buf_pkg.sv
// ============================================================================
// Module   : cf_fft_buf_pkg
// Purpose  : Shared definitions for the sequential-write / ordered-read
//            ping-pong sample buffer: default widths, derived bank depth and
//            the read-side state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cf_fft_buf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    // Read side: EMPTY means the read bank holds nothing unconsumed,
    // READY means a complete frame is waiting to be read.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        READY = 1'b1
    } rd_state_t;

endpackage : cf_fft_buf_pkg

`default_nettype wire

// File: rtl/cf_fft_buf_bank.sv
// ============================================================================
// Module   : cf_fft_buf_bank
// Purpose  : One 2**ADDR_W x DATA_W storage bank with a single write port and
//            a single registered read port, both qualified by a clock enable.
//            Storage is never cleared; only the read register is reset.
// Ports    : clk_i    - clock
//            rst_i    - asynchronous active-high reset (read register only)
//            en_i     - clock enable, gates both ports
//            we_i     - write strobe
//            waddr_i  - write address
//            wdata_i  - write data
//            re_i     - read strobe
//            raddr_i  - read address
//            rdata_o  - registered read data, holds when not reading
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cf_fft_buf_bank
    import cf_fft_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i && re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : cf_fft_buf_bank

`default_nettype wire

// File: rtl/cf_fft_1024_8_seqwr_buf.sv
// ============================================================================
// Module   : cf_fft_1024_8_seqwr_buf
// Purpose  : Ping-pong frame buffer. Samples are written sequentially into
//            the write bank; once a full frame has been written the banks
//            swap and the completed frame is read back in any externally
//            supplied order (e.g. bit-reversed for an FFT).
// Ports    : clock_c     - sole clock, rising edge
//            reset       - asynchronous active-high reset
//            din         - sample to write
//            din_valid   - din qualifier
//            frame_start - restarts the write count at address 0
//            rd_addr     - read address into the read bank
//            rd_en       - read request
//            enable      - global clock enable
//            dout        - registered read data
//            dout_valid  - dout qualifier
//            frame_ready - read bank holds a complete unconsumed frame
//            overflow    - sticky overflow flag
// Options  : CF_FFT_SEQWR_OVERFLOW_EN - when defined, overflow sets if a new
//            frame completes while the previous one is still unconsumed;
//            otherwise overflow is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cf_fft_1024_8_seqwr_buf
    import cf_fft_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock_c,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_en,
    input  logic              enable,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              frame_ready,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_sel_q, rd_sel_d;     // bank whose read register drives dout
    logic              dout_valid_q, dout_valid_d;
    rd_state_t         state_q, state_d;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic              w_wr;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_swap;
    logic              w_rd_acc;
    logic              w_last_rd;

    assign w_wr      = enable && din_valid;
    // frame_start redirects a coincident write to address 0.
    assign w_wr_addr = frame_start ? '0 : wr_cnt_q;
    assign w_swap    = w_wr && (w_wr_addr == C_LAST_ADDR);
    assign w_rd_acc  = enable && rd_en && (state_q == READY);
    assign w_last_rd = w_rd_acc && (rd_cnt_q == C_LAST_ADDR);

    always_comb begin
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        wr_bank_d    = wr_bank_q;
        rd_sel_d     = rd_sel_q;
        dout_valid_d = dout_valid_q;
        state_d      = state_q;

        if (enable) begin
            dout_valid_d = w_rd_acc;

            if (frame_start) begin
                wr_cnt_d = din_valid ? ADDR_W'(1) : '0;
            end else if (w_wr) begin
                wr_cnt_d = wr_cnt_q + ADDR_W'(1);
            end

            if (w_rd_acc) begin
                rd_sel_d = ~wr_bank_q;
                rd_cnt_d = rd_cnt_q + ADDR_W'(1);
            end

            // A swap always starts a fresh frame on the read side, even when
            // the last read of the previous frame lands on the same edge.
            if (w_swap) begin
                wr_bank_d = ~wr_bank_q;
                rd_cnt_d  = '0;
                state_d   = READY;
            end else if (w_last_rd) begin
                state_d   = EMPTY;
            end
        end
    end

    always_ff @(posedge clock_c or posedge reset) begin
        if (reset) begin
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            wr_bank_q    <= 1'b0;
            rd_sel_q     <= 1'b0;
            dout_valid_q <= 1'b0;
            state_q      <= EMPTY;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_bank_q    <= wr_bank_d;
            rd_sel_q     <= rd_sel_d;
            dout_valid_q <= dout_valid_d;
            state_q      <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage banks. The read strobe goes to the bank that is the read bank
    // before this edge, so a read coinciding with a swap returns old data.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rdata [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cf_fft_buf_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk_i   (clock_c),
            .rst_i   (reset),
            .en_i    (enable),
            .we_i    (w_wr && (wr_bank_q == 1'(b))),
            .waddr_i (w_wr_addr),
            .wdata_i (din),
            .re_i    (w_rd_acc && (wr_bank_q != 1'(b))),
            .raddr_i (rd_addr),
            .rdata_o (w_rdata[b])
        );
    end

    // Both bank read registers hold between reads and clear on reset, so
    // selecting with the registered bank index keeps dout stable and zero
    // after reset.
    assign dout        = w_rdata[rd_sel_q];
    assign dout_valid  = dout_valid_q;
    assign frame_ready = (state_q == READY);

    // ------------------------------------------------------------------
    // Overflow
    // ------------------------------------------------------------------
`ifdef CF_FFT_SEQWR_OVERFLOW_EN
    logic overflow_q;

    // A new frame completing while the old one is still pending discards
    // the unread remainder of the old frame.
    always_ff @(posedge clock_c or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (enable && w_swap && (state_q == READY) && !w_last_rd) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule : cf_fft_1024_8_seqwr_buf

`default_nettype wire

// File: tb/tb_cf_fft_1024_8_seqwr_buf.sv
`timescale 1ns/1ps
`default_nettype none

module tb_cf_fft_1024_8_seqwr_buf;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

`ifdef CF_FFT_SEQWR_OVERFLOW_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic              clock_c = 1'b0;
    logic              reset   = 1'b1;
    logic [DATA_W-1:0] din     = '0;
    logic              din_valid   = 1'b0;
    logic              frame_start = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_en   = 1'b0;
    logic              enable  = 1'b1;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              frame_ready;
    logic              overflow;

    int n_vec  = 0;
    int n_fail = 0;

    cf_fft_1024_8_seqwr_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock_c     (clock_c),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .enable      (enable),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_ready (frame_ready),
        .overflow    (overflow)
    );

    always #5 clock_c = ~clock_c;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clock_c);
        #1;
    endtask

    task automatic idle_inputs();
        din_valid   = 1'b0;
        frame_start = 1'b0;
        rd_en       = 1'b0;
        enable      = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_word(input logic [DATA_W-1:0] d);
        din       = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic read_word(input logic [ADDR_W-1:0] a);
        rd_addr = a;
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic fill_frame(input logic [DATA_W-1:0] base);
        for (int i = 0; i < DEPTH; i++) write_word(base + DATA_W'(i));
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_vec++;
        if ({dout, dout_valid, frame_ready, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dout=%h dv=%b fr=%b ovf=%b, need all 0",
                     dout, dout_valid, frame_ready, overflow);
        end
        do_reset();
    endtask

    task automatic test_empty_read();
        do_reset();
        rd_en   = 1'b1;
        rd_addr = 8'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if (dout_valid !== 1'b0 || frame_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_read cyc %0d: got dv=%b fr=%b, need 0 0",
                         i, dout_valid, frame_ready);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_bitrev_frame();
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) write_word(DATA_W'(i));
        n_vec++;
        if (frame_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_last: got %b, need 0", frame_ready);
        end
        write_word(DATA_W'(255));
        n_vec++;
        if (frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_on_last: got %b, need 1", frame_ready);
        end
        for (int k = 0; k < DEPTH; k++) begin
            read_word(bitrev8(8'(k)));
            n_vec++;
            if (dout_valid !== 1'b1 || dout !== DATA_W'(bitrev8(8'(k)))) begin
                n_fail++;
                $display("FAIL bitrev_read k=%0d: got dout=%h dv=%b, need %h 1",
                         k, dout, dout_valid, DATA_W'(bitrev8(8'(k))));
            end
        end
        n_vec++;
        if (frame_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_drain: got %b, need 0", frame_ready);
        end
        tick();
        n_vec++;
        if (dout_valid !== 1'b0 || dout !== DATA_W'(bitrev8(8'd255))) begin
            n_fail++;
            $display("FAIL dout_hold: got dout=%h dv=%b, need %h 0",
                     dout, dout_valid, DATA_W'(bitrev8(8'd255)));
        end
    endtask

    task automatic test_frame_start();
        do_reset();
        for (int i = 0; i < 100; i++) write_word(32'h100 + DATA_W'(i));
        frame_start = 1'b1;
        write_word(32'h0000_AAAA);
        frame_start = 1'b0;
        n_vec++;
        if (frame_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fs_ready: got %b, need 0", frame_ready);
        end
        // 255 more writes land on addresses 1..255 and complete the frame.
        for (int i = 1; i < DEPTH - 1; i++) write_word(32'h1000 + DATA_W'(i));
        n_vec++;
        if (frame_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fs_ready_early: got %b, need 0", frame_ready);
        end
        write_word(32'h1000 + 32'd255);
        n_vec++;
        if (frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fs_ready_full: got %b, need 1", frame_ready);
        end
        read_word(8'd0);
        n_vec++;
        if (dout !== 32'h0000_AAAA) begin
            n_fail++;
            $display("FAIL fs_addr0: got %h, need 0000aaaa", dout);
        end
        read_word(8'd1);
        n_vec++;
        if (dout !== 32'h0000_1001) begin
            n_fail++;
            $display("FAIL fs_addr1: got %h, need 00001001", dout);
        end
        read_word(8'd99);
        n_vec++;
        if (dout !== 32'h0000_1063) begin
            n_fail++;
            $display("FAIL fs_addr99: got %h, need 00001063", dout);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        fill_frame(32'h2000);
        for (int i = 0; i < 10; i++) read_word(8'(i));
        n_vec++;
        if (dout !== 32'h2009 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_frameA: got dout=%h ovf=%b, need 00002009 0", dout, overflow);
        end
        fill_frame(32'h3000);
        n_vec++;
        if (overflow !== EXP_OVF || frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: got ovf=%b fr=%b, need %b 1", overflow, frame_ready, EXP_OVF);
        end
        read_word(8'd5);
        n_vec++;
        if (dout !== 32'h3005) begin
            n_fail++;
            $display("FAIL ovf_frameB: got %h, need 00003005", dout);
        end
        tick();
        n_vec++;
        if (overflow !== EXP_OVF) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b, need %b", overflow, EXP_OVF);
        end
    endtask

    task automatic test_coincident();
        do_reset();
        fill_frame(32'h4000);
        for (int i = 0; i < DEPTH; i++) begin
            din       = 32'h5000 + DATA_W'(i);
            din_valid = 1'b1;
            rd_addr   = 8'(i);
            rd_en     = 1'b1;
            tick();
            if (i == 0 || i == DEPTH - 1) begin
                n_vec++;
                if (dout !== 32'h4000 + DATA_W'(i) || dout_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL coinc_read i=%0d: got %h dv=%b, need %h 1",
                             i, dout, dout_valid, 32'h4000 + DATA_W'(i));
                end
            end
        end
        idle_inputs();
        n_vec++;
        if (frame_ready !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL coinc_flags: got fr=%b ovf=%b, need 1 0", frame_ready, overflow);
        end
        read_word(8'd3);
        n_vec++;
        if (dout !== 32'h5003) begin
            n_fail++;
            $display("FAIL coinc_frameB: got %h, need 00005003", dout);
        end
    endtask

    task automatic test_enable_hold();
        logic [DATA_W-1:0] held;
        do_reset();
        for (int i = 0; i < 50; i++) write_word(32'h6000 + DATA_W'(i));
        enable    = 1'b0;
        din       = 32'hDEAD;
        din_valid = 1'b1;
        rd_en     = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if (frame_ready !== 1'b0 || dout_valid !== 1'b0 || dout !== '0) begin
            n_fail++;
            $display("FAIL en_hold_wr: got fr=%b dv=%b dout=%h, need 0 0 0",
                     frame_ready, dout_valid, dout);
        end
        idle_inputs();
        for (int i = 50; i < DEPTH; i++) write_word(32'h6000 + DATA_W'(i));
        n_vec++;
        if (frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL en_frame_done: got %b, need 1", frame_ready);
        end
        read_word(8'd50);
        n_vec++;
        if (dout !== 32'h6032) begin
            n_fail++;
            $display("FAIL en_addr50: got %h, need 00006032", dout);
        end
        held    = dout;
        enable  = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 8'd7;
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if (dout !== held || frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL en_hold_rd: got dout=%h fr=%b, need %h 1", dout, frame_ready, held);
        end
        idle_inputs();
        read_word(8'd49);
        n_vec++;
        if (dout !== 32'h6031) begin
            n_fail++;
            $display("FAIL en_addr49: got %h, need 00006031", dout);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        fill_frame(32'h8000);
        read_word(8'd9);
        for (int i = 0; i < 20; i++) write_word(32'h9000);
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({dout, dout_valid, frame_ready, overflow} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got dout=%h dv=%b fr=%b ovf=%b, need all 0",
                     dout, dout_valid, frame_ready, overflow);
        end
        tick();
        reset = 1'b0;
        fill_frame(32'h7000);
        read_word(8'd0);
        n_vec++;
        if (dout !== 32'h7000 || frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_addr0: got %h fr=%b, need 00007000 1", dout, frame_ready);
        end
        read_word(8'd20);
        n_vec++;
        if (dout !== 32'h7014) begin
            n_fail++;
            $display("FAIL post_reset_addr20: got %h, need 00007014", dout);
        end
    endtask

    initial begin
        test_reset();
        test_empty_read();
        test_bitrev_frame();
        test_frame_start();
        test_overflow();
        test_coincident();
        test_enable_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
